// File: rtl/run_length_scanner.sv
// ---------------------------------------------------------------------------
// run_length_scanner
//   Streaming run-length detector. Each accepted WIDTH-bit word is scanned
//   MSB-first for the first bit that differs from the run's leading bit. A run
//   may span any number of words. When the terminating bit is found, the total
//   run length and the position of that bit within the final word are
//   presented on a valid/ready output.
//
// Optional feature macro: RUN_LEN_SATURATE_EN
//   If defined, the accumulator and out_len saturate at 2^COUNT_W-1 instead of
//   wrapping. An extra output out_sat flags a result whose run saturated.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   in_data    input word, bit WIDTH-1 is scanned first
//   in_lead    leading-bit value, sampled only on the first word of a run
//   in_valid   in_data/in_lead are valid
//   in_ready   a word is accepted this cycle when in_valid is also high
//   flush      abandon the run in progress
//   out_len    total run length in bits
//   out_pos    index from the MSB of the terminating bit in the final word
//   out_valid  out_len/out_pos are valid
//   out_sat    (RUN_LEN_SATURATE_EN only) the run saturated
//   out_ready  downstream accepts the result
//
// States:
//   IDLE  | no run open
//   ACCUM | run open, at least one all-leading word consumed
// ---------------------------------------------------------------------------
module run_length_scanner #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16,
  parameter int POS_W   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_lead,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [COUNT_W-1:0] out_len,
  output logic [POS_W-1:0]   out_pos,
  output logic               out_valid,
`ifdef RUN_LEN_SATURATE_EN
  output logic               out_sat,
`endif
  input  logic               out_ready
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]         r_state;
  logic [COUNT_W-1:0] r_acc;
  logic               r_lead_q;
  logic [COUNT_W-1:0] r_out_len;
  logic [POS_W-1:0]   r_out_pos;
  logic               r_out_valid;

  logic               w_lead;
  logic [WIDTH-1:0]   w_diff;
  logic               w_found;
  logic [POS_W-1:0]   w_pos;
  logic               w_accept;
  logic [COUNT_W:0]   w_sum_word;
  logic [COUNT_W:0]   w_sum_len;
  logic [COUNT_W-1:0] w_acc_next;
  logic [COUNT_W-1:0] w_len_next;

  assign w_lead   = (r_state == ST_IDLE) ? in_lead : r_lead_q;
  assign w_diff   = in_data ^ {WIDTH{w_lead}};
  assign in_ready = !flush && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Priority scan from the MSB: the first differing bit wins.
  always_comb begin
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!w_found && w_diff[WIDTH-1-i]) begin
        w_found = 1'b1;
        w_pos   = POS_W'(i);
      end
    end
  end

  // One extra bit on each sum exposes the carry for saturation.
  assign w_sum_word = {1'b0, r_acc} + (COUNT_W+1)'(WIDTH);
  assign w_sum_len  = {1'b0, r_acc} + (COUNT_W+1)'(w_pos);

`ifdef RUN_LEN_SATURATE_EN
  logic r_sat_acc;
  logic r_out_sat;

  assign w_acc_next = w_sum_word[COUNT_W] ? {COUNT_W{1'b1}} : w_sum_word[COUNT_W-1:0];
  assign w_len_next = w_sum_len[COUNT_W]  ? {COUNT_W{1'b1}} : w_sum_len[COUNT_W-1:0];
  assign out_sat    = r_out_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_acc <= 1'b0;
      r_out_sat <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_sat <= 1'b0;
      end
      if (flush) begin
        r_sat_acc <= 1'b0;
      end else if (w_accept) begin
        if (w_found) begin
          r_out_sat <= r_sat_acc || w_sum_len[COUNT_W];
          r_sat_acc <= 1'b0;
        end else begin
          r_sat_acc <= r_sat_acc || w_sum_word[COUNT_W];
        end
      end
    end
  end
`else
  assign w_acc_next = w_sum_word[COUNT_W-1:0];
  assign w_len_next = w_sum_len[COUNT_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_lead_q    <= 1'b0;
      r_out_len   <= '0;
      r_out_pos   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (flush) begin
        r_acc   <= '0;
        r_state <= ST_IDLE;
      end else if (w_accept) begin
        if (r_state == ST_IDLE) begin
          r_lead_q <= in_lead;
        end
        if (w_found) begin
          // A new result overrides the drain clear above.
          r_out_valid <= 1'b1;
          r_out_len   <= w_len_next;
          r_out_pos   <= w_pos;
          r_acc       <= '0;
          r_state     <= ST_IDLE;
        end else begin
          r_acc   <= w_acc_next;
          r_state <= ST_ACCUM;
        end
      end
    end
  end

  assign out_len   = r_out_len;
  assign out_pos   = r_out_pos;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_run_length_scanner.sv
// ---------------------------------------------------------------------------
// tb_run_length_scanner
//   Directed bench. Instance a: WIDTH=8, COUNT_W=16 for general behaviour.
//   Instance b: WIDTH=8, COUNT_W=4 for accumulator overflow (wrap or saturate
//   depending on RUN_LEN_SATURATE_EN).
// ---------------------------------------------------------------------------
module tb_run_length_scanner;

  logic        clk;
  logic        rst;

  logic [7:0]  a_in_data;
  logic        a_in_lead, a_in_valid, a_in_ready, a_flush;
  logic [15:0] a_out_len;
  logic [2:0]  a_out_pos;
  logic        a_out_valid, a_out_ready;

  logic [7:0]  b_in_data;
  logic        b_in_lead, b_in_valid, b_in_ready, b_flush;
  logic [3:0]  b_out_len;
  logic [2:0]  b_out_pos;
  logic        b_out_valid, b_out_ready;
`ifdef RUN_LEN_SATURATE_EN
  logic        a_out_sat, b_out_sat;
`endif

  int n_checks = 0;
  int n_errors = 0;

  run_length_scanner #(.WIDTH(8), .COUNT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_lead(a_in_lead), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .flush(a_flush),
    .out_len(a_out_len), .out_pos(a_out_pos), .out_valid(a_out_valid),
`ifdef RUN_LEN_SATURATE_EN
    .out_sat(a_out_sat),
`endif
    .out_ready(a_out_ready)
  );

  run_length_scanner #(.WIDTH(8), .COUNT_W(4)) u_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_lead(b_in_lead), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .flush(b_flush),
    .out_len(b_out_len), .out_pos(b_out_pos), .out_valid(b_out_valid),
`ifdef RUN_LEN_SATURATE_EN
    .out_sat(b_out_sat),
`endif
    .out_ready(b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] len, input logic [2:0] pos);
    chk({tag, "_valid"}, 32'(a_out_valid), 32'(v));
    chk({tag, "_len"},   32'(a_out_len),   32'(len));
    chk({tag, "_pos"},   32'(a_out_pos),   32'(pos));
  endtask

  task automatic push(input logic [7:0] d, input logic lead);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_lead  = lead;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_in_data = '0; a_in_lead = 1'b0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_lead = 1'b0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_out("reset", 1'b0, 16'd0, 3'd0);
    chk("reset_in_ready", 32'(a_in_ready), 32'd1);
    chk("reset_b_valid", 32'(b_out_valid), 32'd0);
    chk("reset_b_len", 32'(b_out_len), 32'd0);
`ifdef RUN_LEN_SATURATE_EN
    chk("reset_sat", 32'(a_out_sat), 32'd0);
`endif

    // Single word, lead 0
    push(8'b0001_0110, 1'b0);
    a_in_valid = 1'b0;
    chk_out("single", 1'b1, 16'd3, 3'd3);
    tick();
    chk("single_drain", 32'(a_out_valid), 32'd0);

    // Multi-word run, lead 1; in_lead on later words ignored
    push(8'hFF, 1'b1);
    chk("multi_no_out", 32'(a_out_valid), 32'd0);
    push(8'hFF, 1'b0);
    push(8'hC0, 1'b0);
    a_in_valid = 1'b0;
    chk_out("multi", 1'b1, 16'd18, 3'd2);
    tick();

    // All-leading word then a word whose MSB differs
    push(8'hFF, 1'b1);
    push(8'h7F, 1'b0);
    a_in_valid = 1'b0;
    chk_out("msb_term", 1'b1, 16'd8, 3'd0);
    tick();

    // Backpressure
    a_out_ready = 1'b0;
    push(8'b0001_0110, 1'b0);
    a_in_data = 8'h01; a_in_lead = 1'b0;
    #1;
    chk("bp_in_ready_low", 32'(a_in_ready), 32'd0);
    tick();
    chk_out("bp_hold", 1'b1, 16'd3, 3'd3);
    a_out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", 32'(a_in_ready), 32'd1);
    tick();
    a_in_valid = 1'b0;
    chk_out("bp_refill", 1'b1, 16'd7, 3'd7);
    tick();
    chk("bp_drain", 32'(a_out_valid), 32'd0);

    // Flush mid-run
    push(8'h00, 1'b0);
    push(8'h00, 1'b0);
    a_flush = 1'b1; a_in_data = 8'h40;
    #1;
    chk("flush_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    a_flush = 1'b0;
    chk("flush_no_out", 32'(a_out_valid), 32'd0);
    push(8'h40, 1'b0);
    a_in_valid = 1'b0;
    chk_out("flush", 1'b1, 16'd1, 3'd1);
    tick();

    // Reset mid-run
    push(8'h00, 1'b0);
    push(8'h00, 1'b0);
    a_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(8'h40, 1'b0);
    a_in_valid = 1'b0;
    chk_out("rst_mid", 1'b1, 16'd1, 3'd1);
    tick();

    // Back-to-back runs
    push(8'h80, 1'b0);
    chk_out("b2b_0", 1'b1, 16'd0, 3'd0);
    chk("b2b_rdy0", 32'(a_in_ready), 32'd1);
    push(8'h40, 1'b0);
    chk_out("b2b_1", 1'b1, 16'd1, 3'd1);
    chk("b2b_rdy1", 32'(a_in_ready), 32'd1);
    push(8'h01, 1'b0);
    a_in_valid = 1'b0;
    chk_out("b2b_2", 1'b1, 16'd7, 3'd7);
    tick();

    // Narrow accumulator overflow on instance b
    b_in_valid = 1'b1; b_in_lead = 1'b0;
    b_in_data = 8'h00; tick();
    b_in_data = 8'h00; tick();
    b_in_data = 8'h00; tick();
    b_in_data = 8'h80; tick();
    b_in_valid = 1'b0;
    chk("ovf_valid", 32'(b_out_valid), 32'd1);
    chk("ovf_pos", 32'(b_out_pos), 32'd0);
`ifdef RUN_LEN_SATURATE_EN
    chk("ovf_len_sat", 32'(b_out_len), 32'd15);
    chk("ovf_sat", 32'(b_out_sat), 32'd1);
`else
    chk("ovf_len_wrap", 32'(b_out_len), 32'd8);
`endif
    tick();
    chk("ovf_drain", 32'(b_out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/run_length_scanner.md
Name: run_length_scanner

Overview:
- Streaming, parametrised run-length detector for the decode path.
- Scans WIDTH-bit words MSB-first for the first bit that differs from the run's leading bit, and accumulates the run length across any number of words.
- Emits the total run length and the terminating bit position on a valid/ready handshake, so the downstream shifter knows where the remainder field starts.
- Replaces fixed-width combinational leading-bit encoders wherever a run can span word boundaries.

Parameters:
WIDTH, 32, input word width in bits; must be ≥ 2.
COUNT_W, 16, width of the run-length accumulator and output.
POS_W, $clog2(WIDTH), width of the terminating-bit position (derived; do not override).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
in_data  input  WIDTH  input word; bit WIDTH-1 is scanned first
in_lead  input  1  leading-bit value; sampled only on the first word of a run
in_valid  input  1  in_data/in_lead are valid
in_ready  output  1  block accepts a word this cycle
flush  input  1  abandon the run in progress
out_len  output  COUNT_W  total run length in bits
out_pos  output  POS_W  index from the MSB of the terminating bit in the final word
out_valid  output  1  out_len/out_pos are valid
out_ready  input  1  downstream accepts the result

Behaviour:
- Reset: one clock with rst high clears everything.
  - out_valid=0, out_len=0, out_pos=0.
  - acc=0, lead_q=0, state=IDLE.
  - Reset mid-run discards the run silently.
- States:
  - IDLE: no run open.
  - ACCUM: run open; at least one all-leading word has been consumed.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready).
  - A word is accepted when in_valid && in_ready.
  - The output register may be refilled in the same cycle it is drained (back-to-back runs at one word per clock).
- Leading bit:
  - In IDLE, the effective lead is in_lead, and lead_q is loaded from in_lead on accept.
  - In ACCUM, the effective lead is lead_q; in_lead is ignored.
- Scan of an accepted word:
  - p = index from MSB of the first bit != lead (bit WIDTH-1 → p=0).
  - found = any bit != lead.
- Word accepted with found=1:
  - Next cycle: out_valid=1, out_len=acc+p, out_pos=p.
  - acc←0, state←IDLE.
  - Latency is 1 clock from the accept edge to out_valid.
- Word accepted with found=0:
  - acc←acc+WIDTH, state←ACCUM.
  - No output is produced.
- Arithmetic: out_len and acc are COUNT_W wide. Overflow handling is defined under Optional Feature.
- Output stability: out_len/out_pos stay stable while out_valid && !out_ready. out_valid drops the cycle after out_ready, unless a new terminating word is accepted in that same cycle.
- Flush:
  - flush high: acc←0, state←IDLE, in_ready=0.
  - A word presented that cycle is not accepted.
  - A pending output is unaffected and may still drain on out_ready.
- Simultaneous rst and flush: rst wins.
- A terminating bit at the LSB gives p=WIDTH-1.
- An all-leading word followed by a word whose MSB differs gives out_len=acc+0, out_pos=0.

Optional Feature:
Macro: RUN_LEN_SATURATE_EN
- Defined:
  - acc and out_len saturate at 2^COUNT_W-1 instead of wrapping.
  - Extra output port out_sat (1 bit) goes high with out_valid when the run saturated; it resets to 0.
- Not defined:
  - Arithmetic wraps modulo 2^COUNT_W.
  - No out_sat port exists.

Test Plan:
- WIDTH=8, lead=0, single word 8'b0001_0110, out_ready=1 -> one cycle later out_valid=1, out_len=3, out_pos=3.
- WIDTH=8, lead=1, words 8'hFF, 8'hFF, 8'hC0 back-to-back -> single result out_len=18, out_pos=2; in_lead on words 2–3 set to 0 has no effect.
- Backpressure: out_ready=0 after result len=3 -> out_valid, out_len, out_pos held; in_ready=0 until out_ready=1. A new word 8'h01 presented in the drain cycle is accepted and yields out_len=7, out_pos=7 on the next clock.
- Flush: lead=0, words 8'h00, 8'h00, then flush for 1 cycle, then 8'h40 -> out_len=1, out_pos=1, with no trace of the 16 flushed bits. Repeat with rst high mid-run -> identical result.
- COUNT_W=4, WIDTH=8, lead=0, words 8'h00 ×3 then 8'h80:
  - with RUN_LEN_SATURATE_EN: out_len=15, out_sat=1.
  - without: out_len=8 (24 mod 16).
- Back-to-back runs: words 8'h80, 8'h40, 8'h01, lead=0, out_ready=1 held -> results 0/0, 1/1, 7/7 on three consecutive cycles; in_ready stays high throughout.
